// File: rtl/mm_job_sequencer.sv
// mm_job_sequencer
//   Front-end scheduler for the 3x3 matrix multiplier. Two requesters share the
//   multiplier under round-robin arbitration. The granted requester's 18 operand
//   bytes (A then B) are buffered, the multiplier is started and fed one byte per
//   cycle, the 9 result bytes are captured and handed back over valid/ready.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   req[1:0]            job request per requester (held until last result taken)
//   gnt[1:0]            registered one-hot grant
//   in_data0/1, in_valid, in_ready   operand byte stream per requester
//   out_data, out_valid, out_ready   result byte stream (shared data bus)
//   job_err             one-cycle pulse when a job is aborted on timeout
//   busy                controller not idle
//   mm_st, mm_data      multiplier start pulse and operand byte
//   mm_done, mm_dataout multiplier done flag and result byte
module mm_job_sequencer #(
  parameter int W       = 8,
  parameter int N_IN    = 18,
  parameter int N_OUT   = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [1:0]   in_valid,
  output logic [1:0]   in_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_valid,
  input  logic [1:0]   out_ready,
  output logic         job_err,
  output logic         busy,
  output logic         mm_st,
  output logic [W-1:0] mm_data,
  input  logic         mm_done,
  input  logic [W-1:0] mm_dataout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam logic [4:0]    C_IN       = 5'(N_IN);
  localparam logic [4:0]    C_IN_LAST  = 5'(N_IN - 1);
  localparam logic [4:0]    C_OUT_LAST = 5'(N_OUT - 1);
  localparam logic [TW-1:0] C_TMAX     = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SEND, S_WAIT, S_COLLECT, S_DELIVER
  } state_t;

  state_t        r_state, w_next;
  logic [4:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_rr;      // favoured requester for the next grant
  logic          r_g;       // index of the granted requester
  logic [1:0]    r_gnt;
  logic [W-1:0]  r_buf [N_IN];
  logic [W-1:0]  r_res [N_OUT];

  logic         w_req_g, w_acc, w_load_last, w_timeout, w_hs, w_pick;
  logic [W-1:0] w_in_d;

  // Losing req of the granted requester overrides any byte transfer that cycle.
  assign w_req_g     = req[r_g];
  assign w_in_d      = r_g ? in_data1 : in_data0;
  assign w_acc       = (r_state == S_LOAD) && (r_cnt < C_IN) && in_valid[r_g] && w_req_g;
  assign w_load_last = w_acc && (r_cnt == C_IN_LAST);
  assign w_timeout   = (r_state == S_WAIT) && !mm_done && (r_timer == C_TMAX);
  assign w_hs        = (r_state == S_DELIVER) && out_ready[r_g] && w_req_g;
  assign w_pick      = req[r_rr] ? r_rr : ~r_rr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req) w_next = S_LOAD;
      S_LOAD:    if (!w_req_g) w_next = S_IDLE;
                 else if (w_load_last) w_next = S_START;
      S_START:   w_next = S_SEND;
      S_SEND:    if (r_cnt == C_IN_LAST) w_next = S_WAIT;
      S_WAIT:    if (mm_done) w_next = S_COLLECT;
                 else if (r_timer == C_TMAX) w_next = S_IDLE;
      S_COLLECT: if (r_cnt == C_OUT_LAST) w_next = S_DELIVER;
      S_DELIVER: if (!w_req_g || (w_hs && (r_cnt == C_OUT_LAST))) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, timer, grant, arbitration pointer, byte buffers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_timer <= '0;
      r_rr    <= 1'b0;
      r_g     <= 1'b0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|req) begin
          r_g   <= w_pick;
          r_gnt <= w_pick ? 2'b10 : 2'b01;
          r_cnt <= '0;
        end
        S_LOAD: if (w_acc) begin
          r_buf[r_cnt[IW-1:0]] <= w_in_d;
          r_cnt <= r_cnt + 5'd1;
        end
        S_START: r_cnt <= '0;
        S_SEND: begin
          r_cnt   <= (r_cnt == C_IN_LAST) ? '0 : r_cnt + 5'd1;
          r_timer <= '0;
        end
        S_WAIT: begin
          if (mm_done) begin
            r_res[0] <= mm_dataout;
            r_cnt    <= 5'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_COLLECT: begin
          r_res[r_cnt[OW-1:0]] <= mm_dataout;
          r_cnt <= (r_cnt == C_OUT_LAST) ? '0 : r_cnt + 5'd1;
        end
        S_DELIVER: if (w_hs) r_cnt <= r_cnt + 5'd1;
        default: ;
      endcase
      // Every exit to IDLE (done, abort, timeout) releases the grant and
      // turns the pointer away from the requester just served.
      if ((r_state != S_IDLE) && (w_next == S_IDLE)) begin
        r_gnt <= '0;
        r_rr  <= ~r_g;
        r_cnt <= '0;
      end
    end
  end

  // Outputs
  always_comb begin
    gnt       = r_gnt;
    busy      = (r_state != S_IDLE);
    in_ready  = ((r_state == S_LOAD) && (r_cnt < C_IN)) ? r_gnt : 2'b00;
    mm_st     = (r_state == S_START);
    mm_data   = (r_state == S_SEND) ? r_buf[r_cnt[IW-1:0]] : '0;
    out_valid = (r_state == S_DELIVER) ? r_gnt : 2'b00;
    out_data  = (r_state == S_DELIVER) ? r_res[r_cnt[OW-1:0]] : '0;
    job_err   = w_timeout;
  end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Self-checking bench for mm_job_sequencer. A behavioural multiplier model
// consumes mm_data after mm_st and returns the 3x3 product; expected operand
// and result bytes are queued when a job is built and popped as the DUT emits.
module tb_mm_job_sequencer;
  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0, gnt, in_valid = '0, in_ready, out_valid, out_ready = '0;
  logic [7:0] in_data0 = '0, in_data1 = '0, out_data, mm_data, mm_dataout = '0;
  logic       job_err, busy, mm_st, mm_done = 1'b0;

  mm_job_sequencer #(.W(8), .N_IN(18), .N_OUT(9), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_data0(in_data0), .in_data1(in_data1), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .job_err(job_err), .busy(busy), .mm_st(mm_st), .mm_data(mm_data),
    .mm_done(mm_done), .mm_dataout(mm_dataout)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_mis = 0;
  int cyc = 0, n_st = 0, n_jerr = 0, last_send = 0;
  int m_ph = 0, m_k = 0, m_d = 0;
  bit nodone = 1'b0;
  logic [7:0] m_in [18];
  logic [7:0] q_mm [$];
  logic [7:0] q_res [$];
  logic       g_hist [$];
  logic [1:0] prev_g = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mmul(input logic [7:0] m [18], input int idx);
    int s = 0;
    for (int k = 0; k < 3; k++) s += m[(idx / 3) * 3 + k] * m[9 + k * 3 + (idx % 3)];
    return 8'(s);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: samples 18 bytes after mm_st, returns results later.
  always @(negedge clk) begin
    mm_done    = 1'b0;
    mm_dataout = '0;
    if (!rst) begin
      m_ph = 0; m_k = 0;
    end else if (mm_st) begin
      n_st++; m_ph = 1; m_k = 0;
    end else begin
      case (m_ph)
        1: begin
          if (q_mm.size() > 0) chk("mm_data", mm_data, q_mm.pop_front());
          else chk("mm_q_empty", q_mm.size(), 1);
          m_in[m_k] = mm_data;
          m_k++;
          if (m_k == 18) begin m_ph = 2; m_d = 0; last_send = cyc; end
        end
        2: if (!nodone) begin
          m_d++;
          if (m_d == 5) begin m_ph = 3; m_k = 0; end
        end
        3: begin
          mm_done = 1'b1;
          mm_dataout = mmul(m_in, m_k);
          m_k++;
          if (m_k == 9) m_ph = 0;
        end
        default: ;
      endcase
    end
  end

  // Grant monitor: every new grant is one-hot and preceded by an idle gnt.
  always @(negedge clk) begin
    if (job_err) n_jerr++;
    if (gnt != prev_g && gnt != 2'b00) begin
      chk("gnt_gap", prev_g, 0);
      chk("gnt_1hot", $onehot(gnt), 1);
      g_hist.push_back(gnt[1]);
    end
    prev_g = gnt;
  end

  task automatic do_reset();
    rst = 1'b0; req = '0; in_valid = '0; out_ready = '0;
    @(negedge clk);
    chk("rst_out", {gnt, in_ready, out_valid, job_err, busy, mm_st, mm_data, out_data}, 0);
    rst = 1'b1;
    q_mm.delete(); q_res.delete();
    @(negedge clk);
  endtask

  // mode: 0 normal, 1 drop req after 10 bytes, 2 reset in SEND,
  //       3 reset in COLLECT, 4 expect timeout
  task automatic do_job(input int r, input bit directed, input bit gaps, input int mode);
    logic [7:0] ops [18];
    logic [7:0] exp1 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int w, idx, nrdy, got, guard, st0, e0;
    bit v, acc, rdy, pstall;
    logic [7:0] pdata;
    for (int i = 0; i < 18; i++)
      ops[i] = directed ? 8'((i < 9) ? i + 1 : 18 - i) : 8'($urandom_range(0, 255));
    for (int i = 0; i < 18; i++) q_mm.push_back(ops[i]);
    for (int i = 0; i < 9; i++) q_res.push_back(directed ? exp1[i] : mmul(ops, i));
    st0 = n_st; e0 = n_jerr;
    req[r] = 1'b1;
    w = 0;
    while (!gnt[r] && w < 40) begin @(negedge clk); w++; end
    if (!gnt[r]) begin
      chk("gnt_wait", gnt, 2'b01 << r);
      q_mm.delete(); q_res.delete();
      return;
    end
    chk("rdy_other", in_ready[1-r], 0);
    idx = 0; nrdy = 0; guard = 0;
    while (idx < 18 && guard < 300) begin
      if (in_ready[r]) nrdy++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = '0;
      in_valid[r] = v;
      in_valid[1-r] = 1'b1;
      if (r == 0) begin in_data0 = ops[idx]; in_data1 = 8'hEE; end
      else        begin in_data1 = ops[idx]; in_data0 = 8'hEE; end
      acc = v && in_ready[r];
      @(negedge clk); guard++;
      if (acc) idx++;
      if (mode == 1 && idx == 10) begin
        req[r] = 1'b0; in_valid = '0;
        repeat (3) @(negedge clk);
        chk("ab_busy", {busy, gnt}, 0);
        chk("ab_st", n_st - st0, 0);
        chk("ab_err", n_jerr - e0, 0);
        q_mm.delete(); q_res.delete();
        return;
      end
    end
    in_valid = '0;
    if (idx < 18) chk("load_to", idx, 18);
    if (!gaps) begin
      chk("rdy_cycles", nrdy, 18);
      chk("rdy_drop", in_ready[r], 0);
      chk("mm_st_now", mm_st, 1);
    end
    got = 0; guard = 0; pstall = 1'b0; pdata = '0;
    while (got < 9 && guard < 3000) begin
      if ((mode == 2 && m_ph == 1 && m_k == 6) || (mode == 3 && m_ph == 3 && m_k == 4)) begin
        do_reset();
        return;
      end
      if (mode == 4 && job_err) begin
        chk("to_lat", cyc - last_send, TO + 1);
        req[1] = 1'b1;
        @(negedge clk);
        chk("to_clr", {gnt, job_err}, 0);
        @(negedge clk);
        chk("to_next", gnt, 2'b10);
        req[0] = 1'b0;
        q_mm.delete(); q_res.delete();
        return;
      end
      if (pstall) chk("out_hold", {out_valid[r], out_data}, {1'b1, pdata});
      rdy = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = '0;
      out_ready[r] = rdy;
      if (out_valid[r] && rdy) begin
        if (q_res.size() > 0) chk("res", out_data, q_res.pop_front());
        else chk("res_q_empty", q_res.size(), 1);
        chk("ov_other", out_valid[1-r], 0);
        got++;
      end
      pstall = out_valid[r] && !rdy;
      pdata = out_data;
      @(negedge clk); guard++;
    end
    out_ready = '0;
    if (got < 9) chk("res_to", got, 9);
    chk("done_idle", {busy, gnt}, 0);
    chk("st_cnt", n_st - st0, 1);
  endtask

  initial begin
    int h;
    repeat (3) @(negedge clk);
    chk("rst_state", {gnt, in_ready, out_valid, job_err, busy, mm_st, mm_data, out_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed single job from requester 0
    h = g_hist.size();
    do_job(0, 1'b1, 1'b0, 0);
    req = '0;
    chk("g_first", g_hist[h], 0);

    // Both requesting from reset: grants 0,1,0
    do_reset();
    h = g_hist.size();
    req = 2'b11;
    do_job(0, 1'b0, 1'b0, 0);
    do_job(1, 1'b0, 1'b0, 0);
    do_job(0, 1'b0, 1'b0, 0);
    req = '0;
    chk("g_ord", {g_hist[h], g_hist[h+1], g_hist[h+2]}, 3'b010);

    // Backpressure on both sides
    do_job(1, 1'b0, 1'b1, 0); req = '0;
    do_job(0, 1'b0, 1'b1, 0); req = '0;
    @(negedge clk);

    // Requester 0 withdraws during LOAD; requester 1 goes next
    do_job(0, 1'b0, 1'b0, 1);
    h = g_hist.size();
    req = 2'b11;
    do_job(1, 1'b0, 1'b0, 0);
    do_job(0, 1'b0, 1'b0, 0);
    req = '0;
    chk("g_after_ab", {g_hist[h], g_hist[h+1]}, 2'b10);

    // Timeout with the multiplier never finishing
    @(negedge clk);
    nodone = 1'b1;
    do_job(0, 1'b0, 1'b0, 4);
    nodone = 1'b0;
    do_job(1, 1'b0, 1'b0, 0);
    req = '0;

    // Reset in SEND and in COLLECT, each followed by a fresh job
    @(negedge clk);
    do_job(0, 1'b0, 1'b0, 2);
    do_job(0, 1'b1, 1'b0, 0); req = '0;
    @(negedge clk);
    do_job(1, 1'b0, 1'b0, 3);
    do_job(1, 1'b0, 1'b1, 0); req = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
